shift_add_mult: RTL and testbench
=================================

SHIFT_ADD_MULT -- requirements
Module: shift_add_mult

Interface
REQ-001 Parameter: width, default 8, operand width in bits; product is 2*width bits.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 start  input  1  request; sampled on rising edge of clk.
REQ-005 a  input  width  multiplicand, held steady by the upstream operand registers.
REQ-006 b  input  width  multiplier, held steady by the upstream operand registers.
REQ-007 product  output  2*width  result; registered.
REQ-008 busy  output  1  high while state is RUN.
REQ-009 done  output  1  one-cycle pulse when product becomes valid.

Function
REQ-010 FSM states: IDLE, RUN, DONE; encoding from the shared package.
REQ-011 IDLE with start=1 at edge N: latch a into multiplicand shift reg and b into multiplier shift reg, clear accumulator, load counter=width, go RUN.
REQ-012 RUN, each edge: if multiplier LSB=1, add zero-extended multiplicand to accumulator; shift multiplicand left 1, multiplier right 1, decrement counter.
REQ-013 RUN exits to DONE on the edge where the counter reaches 0, i.e. edge N+width; product loaded from accumulator on that edge.
REQ-014 DONE lasts exactly one cycle with done=1, then goes to IDLE; start=1 in DONE is accepted as in IDLE (back-to-back, next done at N'+width).
REQ-015 start during RUN is ignored; a/b changes during RUN do not affect the result.
REQ-016 Latency: done high in the cycle after edge N+width; busy high for exactly width cycles.
REQ-017 Accumulator is 2*width bits; no overflow possible; unsigned product of max operands is (2^width-1)^2.
REQ-018 product holds its value from DONE until the next DONE; it is not cleared by a new start.
REQ-019 Zero operand: still takes full width cycles; product=0.

Reset
REQ-020 reset=1 forces asynchronously: state IDLE, product 0, busy 0, done 0, accumulator/shift regs/counter 0.
REQ-021 Reset mid-RUN aborts the operation; no done pulse is produced for it.
REQ-022 First start is accepted on the first rising edge after reset deasserts.

Configuration
REQ-023 Macro MULT_SIGNED_EN: when defined, a, b and product are two's complement.
REQ-024 With MULT_SIGNED_EN: at start, latch |a| and |b| (width-bit unsigned, so -2^(width-1) maps to 2^(width-1)) and the sign XOR; in DONE, product = negated accumulator if the sign XOR is 1. Latency is unchanged.
REQ-025 Without MULT_SIGNED_EN: unsigned only; no sign logic is synthesized.

Structure
REQ-026 Shared package mult_pkg: state encoding constants (IDLE, RUN, DONE) and the default width constant.
REQ-027 One sub-module, mult_datapath: shift regs, accumulator, adder and counter; shift_add_mult holds the FSM and drives its control enables.

Verification
REQ-028 a=13, b=11, start pulse at edge N -> busy for 8 cycles, done at cycle N+9, product=0x008F.
REQ-029 a=255, b=255 -> product=0xFE01; a=0, b=200 -> product=0x0000 after the full 8 cycles.
REQ-030 start re-asserted with a=1, b=1 during RUN of 13*11 -> ignored, product=0x008F, single done pulse.
REQ-031 reset pulsed at RUN cycle 4 -> immediate IDLE, product=0, busy=0, no done; next start 2*3 -> product=0x0006.
REQ-032 Back-to-back: start held high through DONE with a=2, b=3 then a=4, b=5 -> done pulses 9 cycles apart, products 0x0006 then 0x0014.
REQ-033 MULT_SIGNED_EN: a=-3, b=5 -> 0xFFF1; a=-128, b=-128 -> 0x4000; a=-1, b=127 -> 0xFF81.

Source files
------------

// File: rtl/mult_pkg.sv
// Shared constants for the shift-add multiplier: FSM state encoding and default operand width.
package mult_pkg;

  localparam int WIDTH_DEF = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/mult_datapath.sv
// Multiplier datapath: operand shift registers, accumulator/adder, step counter and product register.
// Two's complement operands are handled when MULT_SIGNED_EN is defined (magnitudes in, sign fix-up on the result).
module mult_datapath
  import mult_pkg::*;
#(
  parameter int width = WIDTH_DEF
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 load,
  input  logic                 step,
  input  logic [width-1:0]     a,
  input  logic [width-1:0]     b,
  output logic                 last,
  output logic [2*width-1:0]   product
);

  localparam int CW = $clog2(width + 1);

  logic [2*width-1:0] mcand_q, mcand_d;
  logic [2*width-1:0] acc_q, acc_d;
  logic [2*width-1:0] product_q, product_d;
  logic [width-1:0]   mplier_q, mplier_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [width-1:0]   a_mag, b_mag;
  logic [2*width-1:0] result;

`ifdef MULT_SIGNED_EN
  logic neg_q, neg_d;

  // Most negative value maps to 2^(width-1), which still fits unsigned in width bits.
  assign a_mag  = a[width-1] ? -a : a;
  assign b_mag  = b[width-1] ? -b : b;
  assign neg_d  = load ? (a[width-1] ^ b[width-1]) : neg_q;
  assign result = neg_q ? -acc_d : acc_d;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) neg_q <= 1'b0;
    else       neg_q <= neg_d;
  end
`else
  assign a_mag  = a;
  assign b_mag  = b;
  assign result = acc_d;
`endif

  assign last    = (cnt_q == CW'(1));
  assign product = product_q;

  always_comb begin
    mcand_d   = mcand_q;
    mplier_d  = mplier_q;
    acc_d     = acc_q;
    cnt_d     = cnt_q;
    product_d = product_q;
    if (load) begin
      mcand_d  = {{width{1'b0}}, a_mag};
      mplier_d = b_mag;
      acc_d    = '0;
      cnt_d    = CW'(width);
    end else if (step) begin
      if (mplier_q[0]) acc_d = acc_q + mcand_q;
      mcand_d  = mcand_q << 1;
      mplier_d = mplier_q >> 1;
      cnt_d    = cnt_q - CW'(1);
      // The final step's sum goes straight into the product so it is valid with done.
      if (last) product_d = result;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mcand_q   <= '0;
      mplier_q  <= '0;
      acc_q     <= '0;
      cnt_q     <= '0;
      product_q <= '0;
    end else begin
      mcand_q   <= mcand_d;
      mplier_q  <= mplier_d;
      acc_q     <= acc_d;
      cnt_q     <= cnt_d;
      product_q <= product_d;
    end
  end

endmodule

// File: rtl/shift_add_mult.sv
// Sequential shift-add multiplier: width cycles busy, then a one-cycle done with a registered product.
// Define MULT_SIGNED_EN for two's complement operands and product; default build is unsigned.
module shift_add_mult
  import mult_pkg::*;
#(
  parameter int width = WIDTH_DEF
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic [width-1:0]     a,
  input  logic [width-1:0]     b,
  output logic [2*width-1:0]   product,
  output logic                 busy,
  output logic                 done
);

  state_t state_q, state_d;
  logic   load, step, last;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = RUN;
      RUN:     if (last)  state_d = DONE;
      DONE:    state_d = start ? RUN : IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Start is honoured in DONE as well as IDLE so operations can run back to back.
  always_comb begin
    load = start && ((state_q == IDLE) || (state_q == DONE));
    step = (state_q == RUN);
    busy = (state_q == RUN);
    done = (state_q == DONE);
  end

  mult_datapath #(.width(width)) u_datapath (
    .clk     (clk),
    .reset   (reset),
    .load    (load),
    .step    (step),
    .a       (a),
    .b       (b),
    .last    (last),
    .product (product)
  );

endmodule

// File: tb/tb_shift_add_mult.sv
// Self-checking bench for shift_add_mult (width 8): vector table, random ops against a reference model, corner sequences.
module tb_shift_add_mult;

  logic        clk;
  logic        reset;
  logic        start;
  logic [7:0]  a;
  logic [7:0]  b;
  logic [15:0] product;
  logic        busy;
  logic        done;

  int tests;
  int fails;

  typedef struct {
    logic [7:0]  a;
    logic [7:0]  b;
    logic [15:0] p;
  } vec_t;

  vec_t vecs[5];

  shift_add_mult #(.width(8)) dut (
    .clk     (clk),
    .reset   (reset),
    .start   (start),
    .a       (a),
    .b       (b),
    .product (product),
    .busy    (busy),
    .done    (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [15:0] ref_mul(input logic [7:0] x, input logic [7:0] y);
    int p;
`ifdef MULT_SIGNED_EN
    int sx;
    int sy;
    sx = $signed(x);
    sy = $signed(y);
    p  = sx * sy;
`else
    p = int'(x) * int'(y);
`endif
    return 16'(p);
  endfunction

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  // Called at a negedge; the following posedge is edge N. Returns at the negedge after done.
  task automatic run_op(input logic [7:0] ta, input logic [7:0] tbv, input logic [15:0] exp);
    int busy_cnt;
    int done_at;
    a = ta;
    b = tbv;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    a = 8'($urandom);
    b = 8'($urandom);
    busy_cnt = 0;
    done_at  = 0;
    for (int i = 1; i <= 20 && done_at == 0; i++) begin
      if (done) done_at = i;
      else begin
        if (busy) busy_cnt++;
        @(negedge clk);
      end
    end
    check("busy_cycles", 32'(busy_cnt), 32'd8);
    check("done_latency", 32'(done_at), 32'd9);
    check("product", 32'(product), 32'(exp));
    @(negedge clk);
    check("done_single_pulse", 32'(done), 32'd0);
  endtask

  initial begin
    int n_done;
    int d_at[2];
    logic [15:0] d_prod[2];
    logic [15:0] seen_prod;

    tests = 0;
    fails = 0;
`ifdef MULT_SIGNED_EN
    vecs[0] = '{8'hFD, 8'd5,   16'hFFF1};
    vecs[1] = '{8'h80, 8'h80,  16'h4000};
    vecs[2] = '{8'hFF, 8'd127, 16'hFF81};
    vecs[3] = '{8'd13, 8'd11,  16'h008F};
    vecs[4] = '{8'd0,  8'd200, 16'h0000};
`else
    vecs[0] = '{8'd13,  8'd11,  16'h008F};
    vecs[1] = '{8'd255, 8'd255, 16'hFE01};
    vecs[2] = '{8'd0,   8'd200, 16'h0000};
    vecs[3] = '{8'd1,   8'd1,   16'h0001};
    vecs[4] = '{8'd128, 8'd2,   16'h0100};
`endif

    reset = 1'b1;
    start = 1'b0;
    a = '0;
    b = '0;
    repeat (2) @(negedge clk);
    check("reset_product", 32'(product), 32'd0);
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_done", 32'(done), 32'd0);
    reset = 1'b0;

    // First start lands on the first edge after reset release.
    for (int i = 0; i < 5; i++) run_op(vecs[i].a, vecs[i].b, vecs[i].p);

    for (int i = 0; i < 20; i++) begin
      logic [7:0] ra;
      logic [7:0] rb;
      ra = 8'($urandom);
      rb = 8'($urandom);
      run_op(ra, rb, ref_mul(ra, rb));
    end

    // Start pulse with new operands during RUN must be ignored.
    a = 8'd13;
    b = 8'd11;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
    start = 1'b1;
    a = 8'd1;
    b = 8'd1;
    @(negedge clk);
    start = 1'b0;
    n_done = 0;
    seen_prod = '0;
    for (int i = 0; i < 15; i++) begin
      if (done) begin
        n_done++;
        seen_prod = product;
      end
      @(negedge clk);
    end
    check("ignored_start_done_count", 32'(n_done), 32'd1);
    check("ignored_start_product", 32'(seen_prod), 32'h008F);

    // Asynchronous reset in the middle of RUN aborts the operation.
    a = 8'd13;
    b = 8'd11;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    #1 reset = 1'b1;
    #1;
    check("midrun_reset_busy", 32'(busy), 32'd0);
    check("midrun_reset_product", 32'(product), 32'd0);
    check("midrun_reset_done", 32'(done), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    n_done = 0;
    for (int i = 0; i < 12; i++) begin
      if (done || busy) n_done++;
      @(negedge clk);
    end
    check("aborted_op_activity", 32'(n_done), 32'd0);
    run_op(8'd2, 8'd3, 16'h0006);

    // Back-to-back: start held high through DONE.
    a = 8'd2;
    b = 8'd3;
    start = 1'b1;
    n_done = 0;
    d_at[0] = 0;
    d_at[1] = 0;
    d_prod[0] = '0;
    d_prod[1] = '0;
    for (int i = 1; i <= 30 && n_done < 2; i++) begin
      @(negedge clk);
      if (done) begin
        d_at[n_done]   = i;
        d_prod[n_done] = product;
        n_done++;
        if (n_done == 1) begin
          a = 8'd4;
          b = 8'd5;
        end
      end
      if (n_done == 1 && i == d_at[0] + 1) start = 1'b0;
      if (n_done == 1 && i == d_at[0] + 4) begin
        check("product_held_during_run", 32'(product), 32'h0006);
        check("busy_second_run", 32'(busy), 32'd1);
      end
    end
    start = 1'b0;
    check("b2b_done_count", 32'(n_done), 32'd2);
    check("b2b_spacing", 32'(d_at[1] - d_at[0]), 32'd9);
    check("b2b_product0", 32'(d_prod[0]), 32'h0006);
    check("b2b_product1", 32'(d_prod[1]), 32'h0014);

    repeat (3) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
